// File: rtl/axi_read_responder.sv
// AXI4 INCR read responder over a backdoor-loaded word RAM.
// Optional AXI_RESP_ADDR_ERR_EN: out-of-range beats return SLVERR.
module axi_read_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  bd_wen,
  input  logic [ADDR_WIDTH-1:0] bd_waddr,
  input  logic [31:0]           bd_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  localparam logic [3:0] WAIT_LAST =
    4'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_t state, state_n;
  logic [3:0] wcnt, wcnt_n;
  logic [7:0] beat, len_q;
  logic [ADDR_WIDTH-1:0] addr_q, rd_addr, ar_word;
  logic hs, rd_en, hit;
  logic dv_q, byp_q;
  logic [31:0] byp_d, ram_q;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic unused_bits;

  assign ar_word = araddr[ADDR_WIDTH+1:2];
  assign arready = resetn && state == IDLE;
  assign hs      = arvalid && arready;
  assign rvalid  = state == BURST;
  assign rlast   = rvalid && beat == len_q;
  assign hit     = bd_wen && bd_waddr == rd_addr;

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    unique case (state)
      IDLE: begin
        if (hs) begin
          if (LATENCY == 1) begin
            state_n = BURST;
            rd_en   = 1'b1;
            rd_addr = ar_word;
          end else begin
            state_n = WAIT;
            wcnt_n  = 4'd0;
          end
        end
      end
      WAIT: begin
        if (wcnt == WAIT_LAST) begin
          state_n = BURST;
          rd_en   = 1'b1;
        end else begin
          wcnt_n = wcnt + 4'd1;
        end
      end
      BURST: begin
        if (rready) begin
          if (beat == len_q) begin
            state_n = IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = addr_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      wcnt   <= 4'd0;
      beat   <= 8'd0;
      len_q  <= 8'd0;
      addr_q <= '0;
      dv_q   <= 1'b0;
      byp_q  <= 1'b0;
      byp_d  <= 32'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (hs) begin
        len_q  <= arlen;
        beat   <= 8'd0;
        addr_q <= ar_word;
      end else if (rd_en) begin
        addr_q <= rd_addr;
        if (state == BURST)
          beat <= beat + 8'd1;
      end
      // same-cycle backdoor write wins over the RAM's old word
      if (rd_en) begin
        dv_q  <= 1'b1;
        byp_q <= hit;
        byp_d <= bd_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bd_wen)
      mem[bd_waddr] <= bd_wdata;
    if (rd_en)
      ram_q <= mem[rd_addr];
  end

`ifdef AXI_RESP_ADDR_ERR_EN
  localparam int HW = 31 - ADDR_WIDTH;

  logic [HW-1:0] hi_q, rd_hi;
  logic err_q;

  // upper word-address bits plus carry, never wrapped
  always_comb begin
    rd_hi = hi_q;
    if (hs)
      rd_hi = {1'b0, araddr[31:ADDR_WIDTH+2]};
    else if (state == BURST)
      rd_hi = hi_q + HW'(&addr_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (hs || rd_en)
        hi_q <= rd_hi;
      if (rd_en)
        err_q <= |rd_hi;
    end
  end

  assign rresp = {dv_q && err_q, 1'b0};
  assign rdata = (!dv_q || err_q) ? 32'd0 :
                 byp_q ? byp_d : ram_q;
  assign unused_bits = &{1'b0, araddr[1:0]};
`else
  assign rresp = 2'b00;
  assign rdata = !dv_q ? 32'd0 :
                 byp_q ? byp_d : ram_q;
  assign unused_bits =
    &{1'b0, araddr[31:ADDR_WIDTH+2], araddr[1:0]};
`endif

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: vector table, corner sequences,
// and random bursts against a word-array reference model.
module tb_axi_read_responder;

  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          bd_wen;
  logic [AW-1:0] bd_waddr;
  logic [31:0]   bd_wdata;

  int tests  = 0;
  int failed = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          mode;
    int          beats;
    logic [31:0] first;
    logic [31:0] last;
    logic [1:0]  lresp;
  } vec_t;

  vec_t tv [7];

  always #5 clk = ~clk;

  axi_read_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .bd_wen  (bd_wen),
    .bd_waddr(bd_waddr),
    .bd_wdata(bd_wdata)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act,
                      input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // expected beat i of a burst from byte address addr
  function automatic void model(input logic [31:0] addr,
                                input int i,
                                output logic [31:0] d,
                                output logic [1:0] r);
    logic [30:0] w;
    w = {1'b0, addr[31:2]} + 31'(i);
    d = ref_mem[w[AW-1:0]];
    r = 2'b00;
`ifdef AXI_RESP_ADDR_ERR_EN
    if (w >= 31'(DEPTH)) begin
      d = 32'd0;
      r = 2'b10;
    end
`endif
  endfunction

  function automatic logic ready_at(input int mode, input int k);
    case (mode)
      1:       return (k % 3) == 0;
      2:       return $urandom_range(0, 2) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [31:0] addr,
                       input logic [7:0] len,
                       input int mode,
                       input bit hold,
                       output int nb,
                       output logic [31:0] d_first,
                       output logic [31:0] d_last,
                       output logic [1:0] r_last,
                       output int acc_wait);
    int lat, cyc, ar_bad, bi;
    bit have, stall, done;
    logic [31:0] ed, pd, wd;
    logic [1:0] er, pr;
    logic pl;
    logic [AW-1:0] wa;
    nb = 0; d_first = '0; d_last = '0; r_last = '0;
    acc_wait = 0; ar_bad = 0; bi = 0;
    have = 0; stall = 0; done = 0;
    pd = '0; pr = '0; pl = 1'b0; ed = '0; er = '0;
    araddr  = addr;
    arlen   = len;
    arvalid = 1'b1;
    while (!arready && acc_wait < 50) begin
      tick();
      acc_wait++;
    end
    chk1("ar_accept", arready, 1'b1);
    if (!arready) begin
      arvalid = 1'b0;
      return;
    end
    tick();
    if (!hold) arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 40) begin
      if (arready) ar_bad++;
      tick();
      lat++;
    end
    chk("latency", lat, LAT);
    if (!rvalid) begin
      arvalid = 1'b0;
      return;
    end
    cyc = 0;
    while (!done && cyc < 4000) begin
      rready = ready_at(mode, cyc);
      bd_wen = 1'b0;
      if (!rvalid) begin
        chk1("rvalid_held", rvalid, 1'b1);
        break;
      end
      if (arready) ar_bad++;
      if (stall) begin
        chk("hold_data", rdata, pd);
        chk("hold_resp", 32'(rresp), 32'(pr));
        chk1("hold_last", rlast, pl);
      end
      if (!have) begin
        model(addr, bi, ed, er);
        have = 1;
      end
      if (mode == 3 ||
          (mode == 2 && $urandom_range(0, 3) == 0)) begin
        wa = addr[AW+1:2] +
             AW'(bi + (mode == 3 ? 1 : $urandom_range(0, 2)));
        wd = $urandom;
        bd_wen      = 1'b1;
        bd_waddr    = wa;
        bd_wdata    = wd;
        ref_mem[wa] = wd;
      end
      if (rready) begin
        chk("beat_data", rdata, ed);
        chk("beat_resp", 32'(rresp), 32'(er));
        chk1("beat_last", rlast, bi == int'(len));
        if (bi == 0) d_first = rdata;
        d_last = rdata;
        r_last = rresp;
        nb++;
        have  = 0;
        stall = 0;
        done  = bi == int'(len);
        bi++;
      end else begin
        stall = 1;
        pd = rdata;
        pr = rresp;
        pl = rlast;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    bd_wen = 1'b0;
    chk1("burst_done", done, 1'b1);
    chk("ar_during_burst", ar_bad, 0);
    chk1("end_rvalid", rvalid, 1'b0);
    chk1("end_arready", arready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, aw, n, cyc;
    logic [31:0] df, dl, ed, a;
    logic [1:0] rl, er;
    logic [11:0] word;
    logic [17:0] hi;
    logic [7:0] l;

    resetn = 0; araddr = '0; arlen = '0; arvalid = 0;
    rready = 0; bd_wen = 0; bd_waddr = '0; bd_wdata = '0;

    tv[0] = '{32'h0,   8'd7, 0, 8, 32'hA0, 32'hA7, 2'b00};
    tv[1] = '{32'h0,   8'd7, 1, 8, 32'hA0, 32'hA7, 2'b00};
    tv[3] = '{32'h10,  8'd0, 0, 1, 32'hA4, 32'hA4, 2'b00};
    tv[4] = '{32'h103, 8'd3, 1, 4, 32'hE0, 32'hE3, 2'b00};
`ifdef AXI_RESP_ADDR_ERR_EN
    tv[2] = '{32'h3FFC, 8'd1, 0, 2, 32'h109F, 32'h0, 2'b10};
    tv[5] = '{32'h3FF0, 8'd255, 0, 256, 32'h109C, 32'h0, 2'b10};
    tv[6] = '{32'h10000, 8'd2, 0, 3, 32'h0, 32'h0, 2'b10};
`else
    tv[2] = '{32'h3FFC, 8'd1, 0, 2, 32'h109F, 32'hA0, 2'b00};
    tv[5] = '{32'h3FF0, 8'd255, 0, 256, 32'h109C, 32'h19B, 2'b00};
    tv[6] = '{32'h10000, 8'd2, 0, 3, 32'hA0, 32'hA2, 2'b00};
`endif

    repeat (3) tick();
    chk1("rst_arready", arready, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_rlast", rlast, 1'b0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    resetn = 1;
    #1;
    chk1("post_rst_arready", arready, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      bd_wen     = 1'b1;
      bd_waddr   = AW'(i);
      bd_wdata   = 32'hA0 + 32'(i);
      ref_mem[i] = 32'hA0 + 32'(i);
      tick();
    end
    bd_wen = 1'b0;

    for (int i = 0; i < 7; i++) begin
      burst(tv[i].addr, tv[i].len, tv[i].mode, 0,
            nb, df, dl, rl, aw);
      chk($sformatf("tv%0d_beats", i), nb, tv[i].beats);
      chk($sformatf("tv%0d_first", i), df, tv[i].first);
      chk($sformatf("tv%0d_last", i), dl, tv[i].last);
      chk($sformatf("tv%0d_lresp", i),
          32'(rl), 32'(tv[i].lresp));
    end

    burst(32'h20, 8'd3, 0, 1, nb, df, dl, rl, aw);
    chk("hold1_beats", nb, 4);
    burst(32'h20, 8'd3, 0, 0, nb, df, dl, rl, aw);
    chk("hold2_wait", aw, 0);
    chk("hold2_beats", nb, 4);

    burst(32'h100, 8'd9, 3, 0, nb, df, dl, rl, aw);
    chk("bypass_beats", nb, 10);

    araddr = 32'h0; arlen = 8'd15; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 100) begin
      if (rvalid) n++;
      tick();
      cyc++;
    end
    chk1("rst_mid_valid", rvalid, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("rst_mid_arready", arready, 1'b0);
    tick();
    chk1("rst_mid_rvalid", rvalid, 1'b0);
    chk1("rst_mid_rlast", rlast, 1'b0);
    chk("rst_mid_rdata", rdata, 0);
    tick();
    resetn = 1'b1;
    rready = 1'b0;
    #1;
    chk1("rst_rel_arready", arready, 1'b1);
    burst(32'h8, 8'd0, 0, 0, nb, df, dl, rl, aw);
    model(32'h8, 0, ed, er);
    chk("rst_next_beats", nb, 1);
    chk("rst_next_data", df, ed);

    for (int r = 0; r < 25; r++) begin
      word = 12'($urandom_range(0, DEPTH - 1));
      hi   = ($urandom_range(0, 4) == 0) ?
             18'($urandom_range(1, 3)) : 18'd0;
      a    = {hi, word, 2'($urandom_range(0, 3))};
      l    = ($urandom_range(0, 7) == 0) ?
             8'($urandom_range(32, 255)) :
             8'($urandom_range(0, 15));
      burst(a, l, 2, 0, nb, df, dl, rl, aw);
      chk("rand_beats", nb, int'(l) + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
